// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  // Hex code per key, indexed by {row, col}; entry 0 is row 0 / col 0.
  localparam logic [15:0][3:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

endpackage

// File: rtl/keypad_scanner_clk_counter.sv
// Saturating cycle counter; done is high on the enabled cycle that completes MAX counts.
module clk_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] LAST = W'(MAX - 1);
  localparam logic [W-1:0] TOP  = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TOP)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = en && (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with debounced press/release and key lockout.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_PERIOD     = 2400,
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int REPEAT_CYCLES   = 24000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  if ((SCAN_PERIOD < 2) || (DEBOUNCE_CYCLES < 1) || (REPEAT_CYCLES < 1)) begin : g_bad_params
    $error("keypad_scanner: SCAN_PERIOD must be >= 2, counts must be >= 1");
  end

  scan_state_t state_q, state_d;
  logic [1:0]  col_q, col_d;
  logic [1:0]  row_q, row_d;
  logic [3:0]  cols_q, cols_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_held_q, key_held_d;
  logic [3:0]  rows_meta_q;
  logic [3:0]  rows_s_q;
  logic [3:0]  rows_s;

  logic        any_low;
  logic [1:0]  low_row;
  logic        row_low;
  logic        scan_en, scan_clr, scan_done;
  logic        deb_en, deb_clr, deb_done;
  logic        rep_pulse;

  // Two-flop synchronizer; idle (pulled-up) rows read as 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_meta_q <= 4'hF;
      rows_s_q    <= 4'hF;
    end else begin
      rows_meta_q <= rows;
      rows_s_q    <= rows_meta_q;
    end
  end

  assign rows_s  = rows_s_q;
  assign any_low = ~&rows_s;
  assign row_low = ~rows_s[row_q];

  // Descending loop so the lowest-index low row ends up selected.
  always_comb begin
    low_row = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows_s[i]) begin
        low_row = 2'(i);
      end else begin
        low_row = low_row;
      end
    end
  end

  assign scan_en  = (state_q == SCAN);
  assign scan_clr = (state_q != SCAN) || scan_done;

  clk_counter #(.MAX(SCAN_PERIOD)) u_scan_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (scan_clr),
    .en    (scan_en),
    .done  (scan_done)
  );

  // Shared press/release counter: counts low samples in DEBOUNCE, high samples in HELD.
  assign deb_en  = ((state_q == DEBOUNCE) && row_low) || ((state_q == HELD) && !row_low);
  assign deb_clr = (state_q == SCAN) || ((state_q == DEBOUNCE) && !row_low)
                || ((state_q == HELD) && row_low) || deb_done;

  clk_counter #(.MAX(DEBOUNCE_CYCLES)) u_deb_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (deb_clr),
    .en    (deb_en),
    .done  (deb_done)
  );

`ifdef KEYPAD_REPEAT_EN
  logic rep_en, rep_clr;

  assign rep_en  = (state_q == HELD) && row_low;
  assign rep_clr = (state_q != HELD) || !row_low || rep_pulse;

  clk_counter #(.MAX(REPEAT_CYCLES)) u_rep_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (rep_clr),
    .en    (rep_en),
    .done  (rep_pulse)
  );
`else
  assign rep_pulse = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      SCAN: begin
        if (scan_done && any_low) begin
          row_d   = low_row;
          state_d = DEBOUNCE;
        end else if (scan_done) begin
          col_d = col_q + 2'd1;
        end else begin
          state_d = SCAN;
        end
      end
      DEBOUNCE: begin
        if (!row_low) begin
          state_d = SCAN;
        end else if (deb_done) begin
          key_code_d  = KEY_MAP[{row_q, col_q}];
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = HELD;
        end else begin
          state_d = DEBOUNCE;
        end
      end
      HELD: begin
        if (deb_done) begin
          key_held_d = 1'b0;
          col_d      = col_q + 2'd1;
          state_d    = SCAN;
        end else if (rep_pulse) begin
          key_valid_d = 1'b1;
        end else begin
          state_d = HELD;
        end
      end
      default: begin
        state_d    = SCAN;
        col_d      = 2'd0;
        key_held_d = 1'b0;
      end
    endcase
    cols_d = ~(4'b0001 << col_d);
  end

  // Scanner FSM and its registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      cols_q      <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cols_q      <= cols_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign cols      = cols_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
